led_cube_anim_sequencer: RTL and testbench
==========================================

// Module: led_cube_anim_sequencer
// PURPOSE
//  Parametrised playback sequencer for the LED cube. Steps through frames of N_ANIM stored animations
//  and paces each frame on a cycle timer. Drives the single-frame driver via frame_start/frame_stop.
//  Forms the frame-memory read address and gates output with a 16-level brightness PWM.
//  Modes: playlist, single-repeat and ping-pong. Sits between the config registers and the frame ROM/driver.
// PARAMETERS
//  N_ANIM       7        number of stored animations (>=1)
//  FRAMES       150      frames per animation (>=2)
//  BPF          64       bytes per frame; power of 2
//  FRAME_TICKS  1500000  clk cycles each frame is displayed (>=4)
//  LOOPS        5        full passes per animation before playlist advances (>=1)
//  AW           derived  $clog2(N_ANIM*FRAMES*BPF), mem_addr width
// PORTS
//  clk           in   1                  system clock
//  rst           in   1                  synchronous reset, active-high
//  start         in   1                  pulse: begin playback
//  stop          in   1                  pulse: end playback; has priority over start
//  mode          in   2                  0 off, 1 playlist, 2 single-repeat, 3 single ping-pong
//  anim_sel      in   $clog2(N_ANIM)     animation for modes 2/3; value >=N_ANIM selects 0
//  brightness    in   4                  0 = dark, 15 = lit 15/16 of PWM period
//  byte_addr     in   $clog2(BPF)        byte index requested by the frame driver
//  mem_addr      out  AW                 frame-memory read address
//  frame_start   out  1                  1-cycle pulse: driver begins a frame
//  frame_stop    out  1                  1-cycle pulse: driver aborts
//  blank         out  1                  1 = force Data outputs off this cycle
//  anim_idx      out  $clog2(N_ANIM)     current animation
//  frame_idx     out  $clog2(FRAMES)     current frame
//  busy          out  1                  high in any state other than IDLE
//  anim_wrap     out  1                  1-cycle pulse when playlist wraps N_ANIM-1 -> 0
// BEHAVIOUR
//  Reset: state IDLE; mem_addr, anim_idx, frame_idx, timer, pwm_cnt, loop_cnt = 0;
//   frame_start = frame_stop = anim_wrap = busy = 0; blank = 1.
//  FSM IDLE -> LOAD -> DRIVE <-> ADVANCE.
//   IDLE:    on start with mode!=0, latch mode (and anim_sel in 2/3), go LOAD.
//            start with mode=0 is ignored.
//   LOAD:    one cycle; frame_idx = 0; anim_idx = 0 (mode 1) or clamped anim_sel.
//            Next state DRIVE; frame_start pulses in this cycle.
//   DRIVE:   timer counts 0..FRAME_TICKS-1; at terminal count go ADVANCE.
//   ADVANCE: one cycle; update indices (below); timer = 0; frame_start pulses; next state DRIVE.
//  Frame stepping:
//   Modes 1/2: frame_idx wraps FRAMES-1 -> 0.
//   Mode 3: direction flips at FRAMES-1 and at 0; endpoints shown once per turn
//    (e.g. FRAMES=3: 0,1,2,1,0,1...).
//  Playlist (mode 1):
//   loop_cnt increments at each wrap to frame 0.
//   When a wrap occurs with loop_cnt==LOOPS-1: loop_cnt = 0; anim_idx increments, wrapping
//    N_ANIM-1 -> 0 with anim_wrap pulsed.
//  mode and anim_sel are re-sampled only when frame_idx returns to 0 (modes 1/2)
//   or at the ping-pong turn at 0 (mode 3); mid-animation changes wait.
//   A re-sampled mode 0 acts as stop.
//  mem_addr = anim_idx*FRAMES*BPF + frame_idx*BPF + byte_addr, registered: 1-cycle latency.
//   The driver reads data 2 cycles after byte_addr.
//  PWM: 4-bit pwm_cnt increments every cycle in DRIVE; blank = !(busy && pwm_cnt < brightness).
//   brightness takes effect next cycle.
//  stop, any state including LOAD/ADVANCE:
//   next cycle IDLE; frame_stop pulses once if not already IDLE.
//   Indices, timer and loop_cnt clear to 0.
//  start while busy is ignored. start and stop in the same cycle: stop wins, stays/goes IDLE.
//  rst mid-playback: identical to reset values next cycle; no frame_stop pulse.
// TESTING (N_ANIM=3 FRAMES=3 BPF=4 FRAME_TICKS=8 LOOPS=2)
//  rst, start mode=2 anim_sel=1 -> frame_start pulses every 9 cycles; frame_idx 0,1,2,0.
//   With byte_addr=2, mem_addr = 14,18,22 (14 at frame 0).
//  mode=1, run 6 frames -> anim_idx 0->1 after 2 passes (frame 6); after 18 frames anim_idx 2->0.
//   anim_wrap pulses once at the 2->0 wrap.
//  mode=3 -> frame_idx sequence 0,1,2,1,0,1,2.
//  stop during ADVANCE and start+stop same cycle -> IDLE, one frame_stop pulse, indices 0.
//   In the same-cycle case, busy stays low.
//  brightness 0/8/15 over 16 DRIVE cycles -> blank low for 0/8/15 cycles.
//   Change mode to 2 mid-animation -> takes effect only at the next return of frame_idx to 0.

Source files
------------

// File: rtl/led_cube_anim_sequencer.sv
// LED cube animation sequencer: walks the frames of the stored animations,
// holds each frame for FRAME_TICKS cycles, forms the frame-memory read
// address and gates the data outputs with a 16-level brightness PWM.
module led_cube_anim_sequencer #(
    parameter int N_ANIM      = 7,
    parameter int FRAMES      = 150,
    parameter int BPF         = 64,
    parameter int FRAME_TICKS = 1500000,
    parameter int LOOPS       = 5,
    localparam int AIW = (N_ANIM > 1) ? $clog2(N_ANIM) : 1,
    localparam int FIW = $clog2(FRAMES),
    localparam int BW  = (BPF > 1) ? $clog2(BPF) : 1,
    localparam int AW  = $clog2(N_ANIM * FRAMES * BPF)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic [1:0]     mode,
    input  logic [AIW-1:0] anim_sel,
    input  logic [3:0]     brightness,
    input  logic [BW-1:0]  byte_addr,
    output logic [AW-1:0]  mem_addr,
    output logic           frame_start,
    output logic           frame_stop,
    output logic           blank,
    output logic [AIW-1:0] anim_idx,
    output logic [FIW-1:0] frame_idx,
    output logic           busy,
    output logic           anim_wrap
);

    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    localparam logic [FIW-1:0] LAST_FRAME   = FIW'(FRAMES - 1);
    localparam logic [FIW-1:0] PRE_LAST     = FIW'(FRAMES - 2);
    localparam logic [AIW-1:0] LAST_ANIM    = AIW'(N_ANIM - 1);
    localparam logic [TW-1:0]  LAST_TICK    = TW'(FRAME_TICKS - 1);
    localparam logic [LW-1:0]  LAST_LOOP    = LW'(LOOPS - 1);
    localparam logic [AW-1:0]  ANIM_STRIDE  = AW'(FRAMES * BPF);
    localparam logic [AW-1:0]  FRAME_STRIDE = AW'(BPF);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_DRIVE   = 2'd2,
        S_ADVANCE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [AIW-1:0] anim_q, anim_d;
    logic [FIW-1:0] frame_q, frame_d;
    logic           dir_q, dir_d;        // ping-pong direction, 1 = counting down
    logic [TW-1:0]  timer_q, timer_d;
    logic [LW-1:0]  loop_q, loop_d;
    logic [3:0]     pwm_q, pwm_d;
    logic [3:0]     bright_q;
    logic [AW-1:0]  mem_addr_q;
    logic           frame_stop_q, frame_stop_d;
    logic           anim_wrap_q, anim_wrap_d;
    logic [FIW-1:0] nf;
    logic           nd;
    logic           halt;

    // Out-of-range selections fall back to animation 0.
    function automatic logic [AIW-1:0] clamp_sel(input logic [AIW-1:0] sel);
        return ({1'b0, sel} >= (AIW + 1)'(N_ANIM)) ? '0 : sel;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and index stepping; indices move on entry to LOAD/ADVANCE so
    // they are already valid while frame_start is high.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        anim_d       = anim_q;
        frame_d      = frame_q;
        dir_d        = dir_q;
        timer_d      = timer_q;
        loop_d       = loop_q;
        pwm_d        = pwm_q;
        anim_wrap_d  = 1'b0;
        frame_stop_d = 1'b0;
        halt         = 1'b0;
        nf           = frame_q;
        nd           = dir_q;
        case (state_q)
            S_IDLE: begin
                if (start && mode != 2'd0) begin
                    state_d = S_LOAD;
                    mode_d  = mode;
                    anim_d  = (mode == 2'd1) ? '0 : clamp_sel(anim_sel);
                    frame_d = '0;
                    dir_d   = 1'b0;
                    timer_d = '0;
                    loop_d  = '0;
                end
            end
            S_LOAD: begin
                state_d = S_DRIVE;
                timer_d = '0;
            end
            S_DRIVE: begin
                pwm_d = pwm_q + 4'd1;
                if (timer_q == LAST_TICK) begin
                    timer_d = '0;
                    state_d = S_ADVANCE;
                    if (mode_q == 2'd3) begin
                        if (!dir_q) begin
                            if (frame_q == LAST_FRAME) begin
                                nf = PRE_LAST;
                                nd = 1'b1;
                            end else begin
                                nf = frame_q + 1'b1;
                            end
                        end else begin
                            if (frame_q == '0) begin
                                nf = FIW'(1);
                                nd = 1'b0;
                            end else begin
                                nf = frame_q - 1'b1;
                            end
                        end
                    end else begin
                        nf = (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
                    end
                    frame_d = nf;
                    dir_d   = nd;
                    // Returning to frame 0 is the only point where mode/anim_sel are taken.
                    if (nf == '0) begin
                        if (mode == 2'd0) begin
                            halt = 1'b1;
                        end else begin
                            mode_d = mode;
                            dir_d  = 1'b0;
                            if (mode == 2'd1) begin
                                if (mode_q == 2'd1) begin
                                    if (loop_q == LAST_LOOP) begin
                                        loop_d = '0;
                                        if (anim_q == LAST_ANIM) begin
                                            anim_d      = '0;
                                            anim_wrap_d = 1'b1;
                                        end else begin
                                            anim_d = anim_q + 1'b1;
                                        end
                                    end else begin
                                        loop_d = loop_q + 1'b1;
                                    end
                                end else begin
                                    loop_d = '0;
                                end
                            end else begin
                                anim_d = clamp_sel(anim_sel);
                                loop_d = '0;
                            end
                        end
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_ADVANCE: begin
                state_d = S_DRIVE;
                timer_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (stop || halt) begin
            state_d      = S_IDLE;
            mode_d       = 2'd0;
            anim_d       = '0;
            frame_d      = '0;
            dir_d        = 1'b0;
            timer_d      = '0;
            loop_d       = '0;
            pwm_d        = 4'd0;
            anim_wrap_d  = 1'b0;
            frame_stop_d = (state_q != S_IDLE);
        end
    end

    // Playback registers, brightness sample and registered read address
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 2'd0;
            anim_q       <= '0;
            frame_q      <= '0;
            dir_q        <= 1'b0;
            timer_q      <= '0;
            loop_q       <= '0;
            pwm_q        <= 4'd0;
            bright_q     <= 4'd0;
            mem_addr_q   <= '0;
            frame_stop_q <= 1'b0;
            anim_wrap_q  <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            anim_q       <= anim_d;
            frame_q      <= frame_d;
            dir_q        <= dir_d;
            timer_q      <= timer_d;
            loop_q       <= loop_d;
            pwm_q        <= pwm_d;
            bright_q     <= brightness;
            mem_addr_q   <= AW'(anim_q) * ANIM_STRIDE + AW'(frame_q) * FRAME_STRIDE + AW'(byte_addr);
            frame_stop_q <= frame_stop_d;
            anim_wrap_q  <= anim_wrap_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign frame_start = (state_q == S_LOAD) || (state_q == S_ADVANCE);
    assign blank       = !(busy && (pwm_q < bright_q));
    assign mem_addr    = mem_addr_q;
    assign frame_stop  = frame_stop_q;
    assign anim_wrap   = anim_wrap_q;
    assign anim_idx    = anim_q;
    assign frame_idx   = frame_q;

endmodule

// File: tb/tb_led_cube_anim_sequencer.sv
// Bench for led_cube_anim_sequencer with N_ANIM=3 FRAMES=3 BPF=4
// FRAME_TICKS=8 LOOPS=2.
module tb_led_cube_anim_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [1:0] anim_sel;
    logic [3:0] brightness;
    logic [1:0] byte_addr;
    logic [5:0] mem_addr;
    logic       frame_start;
    logic       frame_stop;
    logic       blank;
    logic [1:0] anim_idx;
    logic [1:0] frame_idx;
    logic       busy;
    logic       anim_wrap;

    led_cube_anim_sequencer #(
        .N_ANIM(3), .FRAMES(3), .BPF(4), .FRAME_TICKS(8), .LOOPS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .anim_sel(anim_sel), .brightness(brightness), .byte_addr(byte_addr),
        .mem_addr(mem_addr), .frame_start(frame_start), .frame_stop(frame_stop),
        .blank(blank), .anim_idx(anim_idx), .frame_idx(frame_idx),
        .busy(busy), .anim_wrap(anim_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         new_run;
        logic [1:0] mode;
        logic [1:0] sel;
        logic [1:0] ba;
        int         ef;
        int         ea;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_fs = 0;
    int wrap_cnt = 0;
    int fstop_cnt = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (anim_wrap) wrap_cnt++;
        if (frame_stop) fstop_cnt++;
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_start_timeout: no pulse within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int f0;
        int low;
        int dcnt;
        int bv[3];

        // new, mode, sel, byte_addr, expected frame, expected anim
        tbl[0]  = '{1'b1, 2'd2, 2'd1, 2'd2, 0, 1};
        tbl[1]  = '{1'b0, 2'd2, 2'd1, 2'd2, 1, 1};
        tbl[2]  = '{1'b0, 2'd2, 2'd1, 2'd2, 2, 1};
        tbl[3]  = '{1'b0, 2'd2, 2'd1, 2'd1, 0, 1};
        tbl[4]  = '{1'b1, 2'd2, 2'd3, 2'd0, 0, 0};
        tbl[5]  = '{1'b0, 2'd2, 2'd3, 2'd3, 1, 0};
        tbl[6]  = '{1'b1, 2'd3, 2'd2, 2'd0, 0, 2};
        tbl[7]  = '{1'b0, 2'd3, 2'd2, 2'd1, 1, 2};
        tbl[8]  = '{1'b0, 2'd3, 2'd2, 2'd2, 2, 2};
        tbl[9]  = '{1'b0, 2'd3, 2'd2, 2'd3, 1, 2};
        tbl[10] = '{1'b0, 2'd3, 2'd2, 2'd0, 0, 2};
        tbl[11] = '{1'b0, 2'd3, 2'd2, 2'd1, 1, 2};
        tbl[12] = '{1'b0, 2'd3, 2'd2, 2'd2, 2, 2};
        tbl[13] = '{1'b1, 2'd1, 2'd0, 2'd0, 0, 0};
        tbl[14] = '{1'b0, 2'd2, 2'd2, 2'd1, 1, 0};
        tbl[15] = '{1'b0, 2'd2, 2'd2, 2'd2, 2, 0};
        tbl[16] = '{1'b0, 2'd2, 2'd2, 2'd3, 0, 2};
        tbl[17] = '{1'b0, 2'd2, 2'd2, 2'd0, 1, 2};

        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; anim_sel = 2'd0;
        brightness = 4'd0; byte_addr = 2'd0;
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_blank", int'(blank), 1);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_frame_stop", int'(frame_stop), 0);
        chk("rst_anim_wrap", int'(anim_wrap), 0);
        chk("rst_anim_idx", int'(anim_idx), 0);
        chk("rst_frame_idx", int'(frame_idx), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        rst = 1'b0;
        step();

        // Table-driven playback runs with read-address scoreboard
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].new_run) begin
                do_stop();
                mode = tbl[i].mode;
                anim_sel = tbl[i].sel;
                start = 1'b1;
                step();
                start = 1'b0;
                chk("load_pulse", int'(frame_start), 1);
            end else begin
                wait_fs(ok);
                chk("frame_interval", cyc - last_fs, 9);
            end
            last_fs = cyc;
            chk("frame_idx", int'(frame_idx), tbl[i].ef);
            chk("anim_idx", int'(anim_idx), tbl[i].ea);
            mode = tbl[i].mode;
            anim_sel = tbl[i].sel;
            byte_addr = tbl[i].ba;
            exp_q.push_back(tbl[i].ea * 12 + tbl[i].ef * 4 + int'(tbl[i].ba));
            step();
            chk("mem_addr", int'(mem_addr), exp_q.pop_front());
        end

        // Playlist: two passes per animation, wrap 2 -> 0 at frame 18
        do_stop();
        mode = 2'd1; anim_sel = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        wrap_cnt = 0;
        last_fs = cyc;
        chk("pl_anim_0", int'(anim_idx), 0);
        for (int k = 1; k <= 18; k++) begin
            wait_fs(ok);
            chk("pl_interval", cyc - last_fs, 9);
            last_fs = cyc;
            chk("pl_frame_idx", int'(frame_idx), k % 3);
            chk("pl_anim_idx", int'(anim_idx), (k / 6) % 3);
            chk("pl_anim_wrap", int'(anim_wrap), (k == 18) ? 1 : 0);
        end
        chk("pl_wrap_count", wrap_cnt, 1);

        // Stop during ADVANCE
        do_stop();
        mode = 2'd3; anim_sel = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_fs(ok);
        chk("adv_anim_before_stop", int'(anim_idx), 2);
        f0 = fstop_cnt;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("adv_stop_busy", int'(busy), 0);
        chk("adv_stop_pulse", int'(frame_stop), 1);
        chk("adv_stop_frame_idx", int'(frame_idx), 0);
        chk("adv_stop_anim_idx", int'(anim_idx), 0);
        repeat (4) step();
        chk("adv_stop_pulse_count", fstop_cnt - f0, 1);
        chk("adv_stop_still_idle", int'(busy), 0);

        // Start and stop in the same cycle from IDLE
        f0 = fstop_cnt;
        mode = 2'd1;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("same_busy", int'(busy), 0);
        chk("same_frame_start", int'(frame_start), 0);
        repeat (3) step();
        chk("same_busy_later", int'(busy), 0);
        chk("same_no_frame_stop", fstop_cnt - f0, 0);

        // Start with mode 0 is ignored
        mode = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("mode0_start_busy", int'(busy), 0);

        // Start while busy is ignored
        mode = 2'd2; anim_sel = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        last_fs = cyc;
        repeat (3) step();
        mode = 2'd3; anim_sel = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        mode = 2'd2; anim_sel = 2'd0;
        wait_fs(ok);
        chk("busy_start_interval", cyc - last_fs, 9);
        chk("busy_start_frame_idx", int'(frame_idx), 1);
        chk("busy_start_anim_idx", int'(anim_idx), 0);

        // Brightness PWM over 16 DRIVE cycles
        bv[0] = 0; bv[1] = 8; bv[2] = 15;
        for (int b = 0; b < 3; b++) begin
            do_stop();
            brightness = 4'(bv[b]);
            mode = 2'd2; anim_sel = 2'd0;
            start = 1'b1;
            step();
            start = 1'b0;
            low = 0;
            dcnt = 0;
            for (int i = 0; i < 40 && dcnt < 16; i++) begin
                step();
                if (busy && !frame_start) begin
                    dcnt++;
                    if (!blank) low++;
                end
            end
            chk("pwm_drive_cycles", dcnt, 16);
            chk("pwm_lit_cycles", low, bv[b]);
        end
        do_stop();
        chk("idle_blank_full_bright", int'(blank), 1);

        // Reset mid-playback
        f0 = fstop_cnt;
        mode = 2'd2; anim_sel = 2'd2; byte_addr = 2'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_frame_stop", int'(frame_stop), 0);
        chk("midrst_frame_idx", int'(frame_idx), 0);
        chk("midrst_anim_idx", int'(anim_idx), 0);
        chk("midrst_mem_addr", int'(mem_addr), 0);
        chk("midrst_blank", int'(blank), 1);
        chk("midrst_frame_start", int'(frame_start), 0);
        rst = 1'b0;
        repeat (2) step();
        chk("midrst_busy_after", int'(busy), 0);
        chk("midrst_no_frame_stop", fstop_cnt - f0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
